// File: rtl/xgmii_rx_deframer_if.sv
// Beat stream produced by the XGMII RX deframer: payload, byte-keep, frame markers and length.
interface xgmii_rx_deframer_if;
  logic [63:0] rx_data;
  logic [7:0]  rx_keep;
  logic        rx_valid;
  logic        rx_sof;
  logic        rx_eof;
  logic        rx_err;
  logic [15:0] rx_len;

  modport master (output rx_data, rx_keep, rx_valid, rx_sof, rx_eof, rx_err, rx_len);
  modport slave  (input  rx_data, rx_keep, rx_valid, rx_sof, rx_eof, rx_err, rx_len);
endinterface

// File: rtl/xgmii_rx_deframer.sv
// Lane-aligned XGMII RX deframer: checks/strips preamble+SFD, emits keep/sof/eof beats
// through a one-word pending register, and counts good and bad frames.
module xgmii_rx_deframer #(
  parameter logic [15:0] MaxLen = 16'd1518,
  parameter logic [15:0] MinLen = 16'd64
) (
  input  logic                        xgmii_rx_clk,
  input  logic                        sys_rst,
  input  logic [63:0]                 xgmii_rxd_i,
  input  logic [7:0]                  xgmii_rxc_i,
  xgmii_rx_deframer_if.master         rx,
  output logic [31:0]                 good_cnt,
  output logic [31:0]                 bad_cnt
);

  localparam logic [1:0]  IDLE = 2'd0;
  localparam logic [1:0]  DATA = 2'd1;
  localparam logic [1:0]  DROP = 2'd2;
  localparam logic [63:0] START_WORD = 64'hD5555555555555FB;

  logic [1:0]  state, state_n;
  logic        pend_valid, pend_valid_n;
  logic [63:0] pend_data, pend_data_n;
  logic [7:0]  pend_keep, pend_keep_n;
  logic        pend_sof, pend_sof_n;
  logic        pend_last, pend_last_n;
  logic        first, first_n;
  logic [15:0] cnt, cnt_n;
  logic        errf, errf_n;

  logic [63:0] o_data;
  logic [7:0]  o_keep;
  logic        o_valid, o_sof, o_eof, o_err;
  logic [15:0] o_len;
  logic        good_inc;
  logic [1:0]  bad_inc;

  // Input word decode
  logic        has_ctl, found, is_term, is_start, bad_pre, tail_err;
  logic [2:0]  k_lane;
  logic [7:0]  part_keep;
  logic [63:0] part_data;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  always_comb begin
    has_ctl   = |xgmii_rxc_i;
    found     = 1'b0;
    k_lane    = '0;
    tail_err  = 1'b0;
    part_data = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (!found && xgmii_rxc_i[i]) begin
        k_lane = 3'(i);
        found  = 1'b1;
      end
    end
    for (int unsigned i = 0; i < 8; i++) begin
      if (i > 32'(k_lane) && !(xgmii_rxc_i[i] && xgmii_rxd_i[8*i +: 8] == 8'h07))
        tail_err = 1'b1;
      if (i < 32'(k_lane))
        part_data[8*i +: 8] = xgmii_rxd_i[8*i +: 8];
    end
    part_keep = ~(8'hFF << k_lane);
    is_term   = has_ctl && (xgmii_rxd_i[{k_lane, 3'b000} +: 8] == 8'hFD);
    is_start  = (xgmii_rxc_i == 8'h01) && (xgmii_rxd_i == START_WORD);
    bad_pre   = xgmii_rxc_i[0] && (xgmii_rxd_i[7:0] == 8'hFB) && !is_start;
  end

  // Each branch only decides whether the pending word leaves and whether it closes
  // the frame; beat formation and counter bookkeeping are shared below.
  always_comb begin
    logic emit, emit_eof, force_err, restart;
    state_n      = state;
    pend_valid_n = pend_valid;
    pend_data_n  = pend_data;
    pend_keep_n  = pend_keep;
    pend_sof_n   = pend_sof;
    pend_last_n  = pend_last;
    first_n      = first;
    cnt_n        = cnt;
    errf_n       = errf;
    emit         = 1'b0;
    emit_eof     = 1'b0;
    force_err    = 1'b0;
    restart      = 1'b0;
    bad_inc      = '0;

    case (state)
      IDLE: begin
        if (pend_valid && pend_last) begin
          emit         = 1'b1;
          emit_eof     = 1'b1;
          pend_valid_n = 1'b0;
          pend_last_n  = 1'b0;
        end
        if (is_start)
          restart = 1'b1;
        else if (bad_pre)
          bad_inc = 2'd1;
      end
      DATA: begin
        if (is_start) begin
          emit         = 1'b1;
          emit_eof     = 1'b1;
          force_err    = 1'b1;
          pend_valid_n = 1'b0;
          restart      = 1'b1;
        end else if (!has_ctl) begin
          emit = 1'b1;
          if (pend_valid && cnt > MaxLen) begin
            emit_eof     = 1'b1;
            pend_valid_n = 1'b0;
            state_n      = DROP;
          end else begin
            pend_valid_n = 1'b1;
            pend_data_n  = xgmii_rxd_i;
            pend_keep_n  = 8'hFF;
            pend_sof_n   = first;
            pend_last_n  = 1'b0;
            first_n      = 1'b0;
            cnt_n        = sat_add(cnt, 16'd8);
          end
        end else if (is_term) begin
          emit      = 1'b1;
          force_err = tail_err;
          state_n   = IDLE;
          if (k_lane == 3'd0 || (pend_valid && cnt > MaxLen)) begin
            emit_eof     = 1'b1;
            pend_valid_n = 1'b0;
          end else begin
            pend_valid_n = 1'b1;
            pend_data_n  = part_data;
            pend_keep_n  = part_keep;
            pend_sof_n   = first;
            pend_last_n  = 1'b1;
            first_n      = 1'b0;
            cnt_n        = sat_add(cnt, {13'd0, k_lane});
            errf_n       = errf | tail_err;
          end
        end else begin
          emit         = 1'b1;
          emit_eof     = 1'b1;
          force_err    = 1'b1;
          pend_valid_n = 1'b0;
          state_n      = IDLE;
        end
      end
      DROP: begin
        if (is_start)
          restart = 1'b1;
        else if (is_term)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (restart) begin
      state_n = DATA;
      first_n = 1'b1;
      cnt_n   = '0;
      errf_n  = 1'b0;
    end

    o_valid  = emit && pend_valid;
    o_data   = '0;
    o_keep   = '0;
    o_sof    = 1'b0;
    o_eof    = 1'b0;
    o_err    = 1'b0;
    o_len    = '0;
    good_inc = 1'b0;
    if (o_valid) begin
      o_data = pend_data;
      o_keep = pend_keep;
      o_sof  = pend_sof;
      o_eof  = emit_eof;
      if (emit_eof) begin
        o_len = cnt;
        o_err = errf | force_err | (cnt < MinLen) | (cnt > MaxLen);
        if (o_err)
          bad_inc = bad_inc + 2'd1;
        else
          good_inc = 1'b1;
      end
    end else if (emit && emit_eof) begin
      bad_inc = bad_inc + 2'd1;
    end
  end

  always_ff @(posedge xgmii_rx_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state       <= IDLE;
      pend_valid  <= 1'b0;
      pend_data   <= '0;
      pend_keep   <= '0;
      pend_sof    <= 1'b0;
      pend_last   <= 1'b0;
      first       <= 1'b0;
      cnt         <= '0;
      errf        <= 1'b0;
      rx.rx_data  <= '0;
      rx.rx_keep  <= '0;
      rx.rx_valid <= 1'b0;
      rx.rx_sof   <= 1'b0;
      rx.rx_eof   <= 1'b0;
      rx.rx_err   <= 1'b0;
      rx.rx_len   <= '0;
      good_cnt    <= '0;
      bad_cnt     <= '0;
    end else begin
      state       <= state_n;
      pend_valid  <= pend_valid_n;
      pend_data   <= pend_data_n;
      pend_keep   <= pend_keep_n;
      pend_sof    <= pend_sof_n;
      pend_last   <= pend_last_n;
      first       <= first_n;
      cnt         <= cnt_n;
      errf        <= errf_n;
      rx.rx_data  <= o_data;
      rx.rx_keep  <= o_keep;
      rx.rx_valid <= o_valid;
      rx.rx_sof   <= o_sof;
      rx.rx_eof   <= o_eof;
      rx.rx_err   <= o_err;
      rx.rx_len   <= o_len;
      good_cnt    <= good_cnt + 32'(good_inc);
      bad_cnt     <= bad_cnt + 32'(bad_inc);
    end
  end

endmodule

// File: tb/tb_xgmii_rx_deframer.sv
// Directed bench for xgmii_rx_deframer: stimulus pushes expected beats (with arrival cycle)
// into a queue; a negedge monitor pops and compares every beat the DUT presents.
module tb_xgmii_rx_deframer;

  localparam logic [63:0] START = 64'hD5555555555555FB;
  localparam logic [63:0] TERM0 = 64'h07070707070707FD;
  localparam logic [63:0] IDLEW = 64'h0707070707070707;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] rxd = IDLEW;
  logic [7:0]  rxc = 8'hFF;
  logic [31:0] good_cnt, bad_cnt;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          exp_good = 0;
  int          exp_bad = 0;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        sof;
    logic        eof;
    logic        err;
    logic [15:0] len;
    int          cyc;
  } beat_t;
  beat_t q[$];

  xgmii_rx_deframer_if rx ();

  xgmii_rx_deframer #(.MaxLen(16'd1518), .MinLen(16'd64)) dut (
    .xgmii_rx_clk (clk),
    .sys_rst      (rst),
    .xgmii_rxd_i  (rxd),
    .xgmii_rxc_i  (rxc),
    .rx           (rx),
    .good_cnt     (good_cnt),
    .bad_cnt      (bad_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] wv(input int i);
    logic [63:0] r;
    for (int j = 0; j < 8; j++) r[8*j +: 8] = 8'(8*i + j);
    return r;
  endfunction

  task automatic drive(input logic [7:0] c, input logic [63:0] d);
    @(negedge clk);
    rxc = c;
    rxd = d;
  endtask

  // Beat carrying bytes of the word just driven is due two cycles later.
  task automatic push(input logic [63:0] d, input logic [7:0] k, input logic s,
                      input logic e, input logic er, input logic [15:0] l);
    beat_t b;
    b.data = d; b.keep = k; b.sof = s; b.eof = e; b.err = er; b.len = l; b.cyc = cyc + 2;
    q.push_back(b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(8'hFF, IDLEW);
  endtask

  task automatic body8();
    for (int i = 0; i < 8; i++) begin
      drive(8'h00, wv(i));
      push(wv(i), 8'hFF, i == 0, i == 7, 1'b0, 16'd64);
    end
    drive(8'hFF, TERM0);
    exp_good++;
  endtask

  task automatic chk_cnt(input string tag);
    idle(4);
    check({tag, "_good_cnt"}, good_cnt, 64'(exp_good));
    check({tag, "_bad_cnt"}, bad_cnt, 64'(exp_bad));
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (rx.rx_valid === 1'b1) begin
      if (q.size() == 0) begin
        check("spurious_beat", 64'(rx.rx_valid), 64'd0);
      end else begin
        e = q.pop_front();
        check("beat_data", rx.rx_data, e.data);
        check("beat_keep", 64'(rx.rx_keep), 64'(e.keep));
        check("beat_sof", 64'(rx.rx_sof), 64'(e.sof));
        check("beat_eof", 64'(rx.rx_eof), 64'(e.eof));
        check("beat_cycle", 64'(cyc), 64'(e.cyc));
        if (e.eof) begin
          check("beat_err", 64'(rx.rx_err), 64'(e.err));
          check("beat_len", 64'(rx.rx_len), 64'(e.len));
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(rx.rx_valid), 64'd0);
    check("rst_data", rx.rx_data, 64'd0);
    check("rst_good", good_cnt, 64'd0);
    check("rst_bad", bad_cnt, 64'd0);
    rst = 1'b0;
    idle(2);

    // Full-word terminate, exactly MinLen
    drive(8'h01, START);
    body8();
    chk_cnt("t1");

    // Terminate in lane 3: partial final beat
    drive(8'h01, START);
    for (int i = 0; i < 8; i++) begin
      drive(8'h00, wv(i));
      push(wv(i), 8'hFF, i == 0, 1'b0, 1'b0, 16'd0);
    end
    drive(8'hF8, 64'h07070707FD424140);
    push(64'h0000000000424140, 8'h07, 1'b0, 1'b1, 1'b0, 16'd67);
    exp_good++;
    chk_cnt("t2");

    // Runt: 56 bytes
    drive(8'h01, START);
    for (int i = 0; i < 7; i++) begin
      drive(8'h00, wv(i));
      push(wv(i), 8'hFF, i == 0, i == 6, 1'b1, 16'd56);
    end
    drive(8'hFF, TERM0);
    exp_bad++;
    chk_cnt("t3");

    // Bad preamble then a good frame
    drive(8'h01, 64'hD5545555555555FB);
    exp_bad++;
    idle(3);
    drive(8'h01, START);
    body8();
    chk_cnt("t4");

    // Zero-byte frame
    drive(8'h01, START);
    drive(8'hFF, TERM0);
    exp_bad++;
    chk_cnt("t_empty");

    // FE error character in lane 2
    drive(8'h01, START);
    for (int i = 0; i < 3; i++) begin
      drive(8'h00, wv(i));
      push(wv(i), 8'hFF, i == 0, i == 2, 1'b1, 16'd24);
    end
    drive(8'h04, 64'h7766554433FE1100);
    exp_bad++;
    idle(2);

    // Start word mid-frame aborts, new frame follows
    drive(8'h01, START);
    for (int i = 0; i < 2; i++) begin
      drive(8'h00, wv(i));
      push(wv(i), 8'hFF, i == 0, i == 1, 1'b1, 16'd16);
    end
    drive(8'h01, START);
    exp_bad++;
    body8();
    chk_cnt("t5");

    // Oversize: 200 words, truncated at beat 190
    drive(8'h01, START);
    for (int i = 0; i < 200; i++) begin
      drive(8'h00, wv(i));
      if (i < 190) push(wv(i), 8'hFF, i == 0, i == 189, 1'b1, 16'd1520);
    end
    drive(8'hFF, TERM0);
    exp_bad++;
    drive(8'h00, wv(3));
    drive(8'h00, wv(4));
    idle(2);
    drive(8'h01, START);
    body8();
    chk_cnt("t6");

    // Reset mid-frame
    drive(8'h01, START);
    drive(8'h00, wv(0));
    push(wv(0), 8'hFF, 1'b1, 1'b0, 1'b0, 16'd0);
    drive(8'h00, wv(1));
    drive(8'h00, wv(2));
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(rx.rx_valid), 64'd0);
    check("mid_rst_data", rx.rx_data, 64'd0);
    check("mid_rst_keep", 64'(rx.rx_keep), 64'd0);
    check("mid_rst_sof", 64'(rx.rx_sof), 64'd0);
    check("mid_rst_len", 64'(rx.rx_len), 64'd0);
    check("mid_rst_good", good_cnt, 64'd0);
    check("mid_rst_bad", bad_cnt, 64'd0);
    rxc = 8'hFF;
    rxd = IDLEW;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_good = 0;
    exp_bad = 0;
    idle(2);
    drive(8'h01, START);
    body8();
    chk_cnt("t7");

    idle(5);
    check("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
